// File: rtl/gpio_config_shift_if.sv
// Serial configuration chain bus between the management core and one pad's
// configuration stage. The management side drives shift/data/load strobes;
// the pad stage returns the forwarded serial bit and its load status.
interface gpio_config_shift_if;

    logic serial_shift;     // shift enable for this cycle
    logic serial_data_in;   // bit from the previous block in the chain
    logic serial_load;      // single-cycle copy strobe, shift_reg -> cfg
    logic serial_data_out;  // registered MSB of the shift register
    logic load_done;        // pulse in the cycle after a load is applied
    logic cfg_partial;      // last load saw fewer than a full word of shifts

    // Management core / previous block in the chain.
    modport master (
        output serial_shift,
        output serial_data_in,
        output serial_load,
        input  serial_data_out,
        input  load_done,
        input  cfg_partial
    );

    // Pad configuration stage.
    modport slave (
        input  serial_shift,
        input  serial_data_in,
        input  serial_load,
        output serial_data_out,
        output load_done,
        output cfg_partial
    );

endinterface

// File: rtl/gpio_config_shift.sv
// Per-pad GPIO configuration stage. Holds the live pad configuration word,
// preset from the tie-cell defaults on reset, and reloads it from a
// daisy-chained serial shift register on a load strobe. The shift register
// MSB is forwarded to the next pad, so each block adds CFG_BITS cycles of
// chain latency. Decoded fields drive the pad cell and the output mux.
module gpio_config_shift #(
    parameter int unsigned CFG_BITS = 10,
    // Must satisfy 2**CNT_W > CFG_BITS so the counter can hold CFG_BITS.
    parameter int unsigned CNT_W    = 4
) (
    input  logic                serial_clock,
    input  logic                resetn,

    input  logic [CFG_BITS-1:0] gpio_defaults,

    gpio_config_shift_if.slave  bus,

    output logic [CFG_BITS-1:0] cfg,
    output logic                mgmt_ena,
    output logic                pad_oeb,
    output logic                hold_override,
    output logic                inp_dis,
    output logic                pu,
    output logic                pd,
    output logic                schmitt,
    output logic                slew,
    output logic [1:0]          drive,

    input  logic                mgmt_gpio_out,
    input  logic                user_gpio_out,
    output logic                pad_out
);

    // Full-word count, compared at counter width.
    localparam logic [CNT_W-1:0] CntFull = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] shift_reg;
    logic [CFG_BITS-1:0] shift_reg_d;
    logic [CNT_W-1:0]    shift_cnt;
    logic [CNT_W-1:0]    shift_cnt_d;
    logic [CFG_BITS-1:0] cfg_reg;
    logic [CFG_BITS-1:0] cfg_reg_d;
    logic                load_done_reg;
    logic                cfg_partial_reg;
    logic                cfg_partial_d;
    logic                cnt_full;

    assign cnt_full = (shift_cnt == CntFull);

    // Next-state for the shift path: MSB-first shift, saturating counter.
    // A load restarts the count, counting this cycle's shift if present.
    always_comb begin
        shift_reg_d = shift_reg;
        shift_cnt_d = shift_cnt;
        if (bus.serial_shift) begin
            shift_reg_d = {shift_reg[CFG_BITS-2:0], bus.serial_data_in};
            if (!cnt_full) begin
                shift_cnt_d = shift_cnt + CNT_W'(1);
            end
        end
        if (bus.serial_load) begin
            shift_cnt_d = bus.serial_shift ? CNT_W'(1) : '0;
        end
    end

    // Next-state for the configuration word: a load captures the pre-shift
    // register value and records whether a complete word had been shifted.
    always_comb begin
        cfg_reg_d     = cfg_reg;
        cfg_partial_d = cfg_partial_reg;
        if (bus.serial_load) begin
            cfg_reg_d     = shift_reg;
            cfg_partial_d = !cnt_full;
        end
    end

    // Shift register and counter; reset discards any partially shifted data.
    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            shift_reg <= '0;
            shift_cnt <= '0;
        end else begin
            shift_reg <= shift_reg_d;
            shift_cnt <= shift_cnt_d;
        end
    end

    // Live configuration register, preset from the tie-cell defaults.
    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            cfg_reg         <= gpio_defaults;
            cfg_partial_reg <= 1'b0;
        end else begin
            cfg_reg         <= cfg_reg_d;
            cfg_partial_reg <= cfg_partial_d;
        end
    end

    // Load completion pulse, one cycle after each load strobe.
    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            load_done_reg <= 1'b0;
        end else begin
            load_done_reg <= bus.serial_load;
        end
    end

    // Chain output and status back onto the bus.
    always_comb begin
        bus.serial_data_out = shift_reg[CFG_BITS-1];
        bus.load_done       = load_done_reg;
        bus.cfg_partial     = cfg_partial_reg;
    end

    // Field decode of the live configuration word; no added latency.
    always_comb begin
        cfg           = cfg_reg;
        mgmt_ena      = cfg_reg[0];
        pad_oeb       = cfg_reg[1];
        hold_override = cfg_reg[2];
        inp_dis       = cfg_reg[3];
        pu            = cfg_reg[4];
        pd            = cfg_reg[5];
        schmitt       = cfg_reg[6];
        slew          = cfg_reg[7];
        drive         = cfg_reg[9:8];
    end

    // Output data mux: management core or user project owns the pad.
    always_comb begin
        pad_out = mgmt_ena ? mgmt_gpio_out : user_gpio_out;
    end

`ifndef SYNTHESIS
    // Counter must never pass the full-word count.
    a_cnt_bound : assert property (@(posedge serial_clock) disable iff (!resetn)
        shift_cnt <= CntFull);

    // Load status reflects the previous cycle's strobe.
    a_load_done : assert property (@(posedge serial_clock) disable iff (!resetn)
        $past(bus.serial_load) == load_done_reg || !$past(resetn));
`endif

endmodule

// File: tb/tb_gpio_config_shift.sv
// Directed bench for gpio_config_shift: reset preset, full and partial
// loads, chain forwarding, simultaneous shift+load, mid-shift reset and the
// pad output mux. Expected values are hand-computed constants.
module tb_gpio_config_shift;

    logic       serial_clock;
    logic       resetn;
    logic [9:0] gpio_defaults;
    logic [9:0] cfg;
    logic       mgmt_ena;
    logic       pad_oeb;
    logic       hold_override;
    logic       inp_dis;
    logic       pu;
    logic       pd;
    logic       schmitt;
    logic       slew;
    logic [1:0] drive;
    logic       mgmt_gpio_out;
    logic       user_gpio_out;
    logic       pad_out;

    int checks;
    int errors;

    gpio_config_shift_if bus ();

    gpio_config_shift #(
        .CFG_BITS (10),
        .CNT_W    (4)
    ) dut (
        .serial_clock  (serial_clock),
        .resetn        (resetn),
        .gpio_defaults (gpio_defaults),
        .bus           (bus.slave),
        .cfg           (cfg),
        .mgmt_ena      (mgmt_ena),
        .pad_oeb       (pad_oeb),
        .hold_override (hold_override),
        .inp_dis       (inp_dis),
        .pu            (pu),
        .pd            (pd),
        .schmitt       (schmitt),
        .slew          (slew),
        .drive         (drive),
        .mgmt_gpio_out (mgmt_gpio_out),
        .user_gpio_out (user_gpio_out),
        .pad_out       (pad_out)
    );

    initial serial_clock = 1'b0;
    always #5 serial_clock = ~serial_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge serial_clock);
        #1;
    endtask

    // Shift the low n bits of v, MSB-first.
    task automatic shift_bits(input logic [9:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.serial_shift   = 1'b1;
            bus.serial_data_in = v[i];
            tick();
        end
        bus.serial_shift   = 1'b0;
        bus.serial_data_in = 1'b0;
    endtask

    task automatic do_load();
        bus.serial_load = 1'b1;
        tick();
        bus.serial_load = 1'b0;
    endtask

    task automatic do_reset(input logic [9:0] defaults);
        gpio_defaults = defaults;
        resetn        = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    logic [19:0] pattern;

    initial begin
        checks             = 0;
        errors             = 0;
        bus.serial_shift   = 1'b0;
        bus.serial_data_in = 1'b0;
        bus.serial_load    = 1'b0;
        mgmt_gpio_out      = 1'b1;
        user_gpio_out      = 1'b0;
        gpio_defaults      = 10'h00a;
        resetn             = 1'b0;

        // Reset preset from defaults.
        tick();
        tick();
        check("rst_cfg", 32'(cfg), 32'h00a);
        check("rst_pad_oeb", 32'(pad_oeb), 32'h1);
        check("rst_inp_dis", 32'(inp_dis), 32'h1);
        check("rst_mgmt_ena", 32'(mgmt_ena), 32'h0);
        check("rst_sdo", 32'(bus.serial_data_out), 32'h0);
        check("rst_load_done", 32'(bus.load_done), 32'h0);
        check("rst_partial", 32'(bus.cfg_partial), 32'h0);
        check("rst_pad_out_user", 32'(pad_out), 32'h0);
        resetn = 1'b1;
        tick();

        // Full 10-bit frame then load.
        shift_bits(10'h3c1, 10);
        check("full_cnt", 32'(dut.shift_cnt), 32'd10);
        check("full_cfg_before_load", 32'(cfg), 32'h00a);
        do_load();
        check("full_cfg", 32'(cfg), 32'h3c1);
        check("full_drive", 32'(drive), 32'h3);
        check("full_mgmt_ena", 32'(mgmt_ena), 32'h1);
        check("full_load_done", 32'(bus.load_done), 32'h1);
        check("full_partial", 32'(bus.cfg_partial), 32'h0);
        check("full_pad_out_mgmt", 32'(pad_out), 32'h1);
        check("full_cnt_cleared", 32'(dut.shift_cnt), 32'd0);
        tick();
        check("full_load_done_drop", 32'(bus.load_done), 32'h0);
        check("full_shift_reg_kept", 32'(dut.shift_reg), 32'h3c1);

        // Chain forwarding: first ten bits reappear ten shifts later.
        pattern = 20'b1011000001_0000000000;
        for (int k = 1; k <= 20; k++) begin
            bus.serial_shift   = 1'b1;
            bus.serial_data_in = pattern[20-k];
            tick();
            if (k >= 10 && k <= 19) begin
                check($sformatf("chain_sdo_%0d", k), 32'(bus.serial_data_out),
                      32'(pattern[29-k]));
            end
        end
        bus.serial_shift = 1'b0;
        check("chain_cfg_hold", 32'(cfg), 32'h3c1);
        check("chain_cnt_sat", 32'(dut.shift_cnt), 32'd10);
        check("chain_load_done", 32'(bus.load_done), 32'h0);

        // Zero-shift load right after reset takes the cleared register.
        do_reset(10'h00a);
        do_load();
        check("zero_cfg", 32'(cfg), 32'h000);
        check("zero_partial", 32'(bus.cfg_partial), 32'h1);

        // Partial load, then full frame.
        shift_bits(10'h007, 3);
        do_load();
        check("part_cfg", 32'(cfg), 32'h007);
        check("part_partial", 32'(bus.cfg_partial), 32'h1);
        shift_bits(10'h155, 10);
        do_load();
        check("part_full_cfg", 32'(cfg), 32'h155);
        check("part_full_partial", 32'(bus.cfg_partial), 32'h0);

        // Back-to-back loads: second one sees zero shifts.
        bus.serial_load = 1'b1;
        tick();
        check("b2b_first_done", 32'(bus.load_done), 32'h1);
        tick();
        bus.serial_load = 1'b0;
        check("b2b_second_done", 32'(bus.load_done), 32'h1);
        check("b2b_cfg", 32'(cfg), 32'h155);
        check("b2b_partial", 32'(bus.cfg_partial), 32'h1);
        tick();
        check("b2b_done_drop", 32'(bus.load_done), 32'h0);

        // Simultaneous shift and load.
        shift_bits(10'h2aa, 10);
        check("sim_shift_reg_pre", 32'(dut.shift_reg), 32'h2aa);
        bus.serial_shift   = 1'b1;
        bus.serial_data_in = 1'b1;
        bus.serial_load    = 1'b1;
        tick();
        bus.serial_shift   = 1'b0;
        bus.serial_data_in = 1'b0;
        bus.serial_load    = 1'b0;
        check("sim_cfg", 32'(cfg), 32'h2aa);
        check("sim_shift_reg", 32'(dut.shift_reg), 32'h155);
        check("sim_cnt", 32'(dut.shift_cnt), 32'd1);
        check("sim_partial", 32'(bus.cfg_partial), 32'h0);

        // Asynchronous reset mid-shift discards shifted data.
        shift_bits(10'h01f, 5);
        gpio_defaults = 10'h0a3;
        #1;
        resetn = 1'b0;
        #1;
        check("mid_rst_cfg", 32'(cfg), 32'h0a3);
        check("mid_rst_cnt", 32'(dut.shift_cnt), 32'd0);
        check("mid_rst_shift_reg", 32'(dut.shift_reg), 32'h000);
        check("mid_rst_pad_out", 32'(pad_out), 32'h1);
        tick();
        resetn = 1'b1;
        tick();
        shift_bits(10'h0f0, 10);
        do_load();
        check("post_rst_cfg", 32'(cfg), 32'h0f0);
        check("post_rst_partial", 32'(bus.cfg_partial), 32'h0);
        check("post_rst_pad_out", 32'(pad_out), 32'h0);
        user_gpio_out = 1'b1;
        #1;
        check("post_rst_pad_out_user", 32'(pad_out), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
